// File: rtl/pt8211_pkg.sv
// Shared definitions for the PT8211 serial audio transmit and receive paths.
package pt8211_pkg;

    localparam int WORD_W = 16;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef logic signed [WORD_W-1:0] sample_t;

    // Link state: DOWN, waiting for a left word, or holding a left word.
    typedef enum logic [1:0] {
        ST_DOWN   = 2'd0,
        ST_WAIT_L = 2'd1,
        ST_HAVE_L = 2'd2
    } rx_state_t;

endpackage

// File: rtl/pt8211_sync_edge.sv
// Multi-stage synchronizer for a small bus of asynchronous inputs, with an
// optional rising-edge detector on bit 0.
module pt8211_sync_edge #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1,
    parameter bit EDGE   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rise
);

    logic [WIDTH-1:0] chain_r [STAGES];

    // Synchronizer flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain_r[i] <= '0;
        end else begin
            chain_r[0] <= d;
            for (int i = 1; i < STAGES; i++) chain_r[i] <= chain_r[i-1];
        end
    end

    assign q = chain_r[STAGES-1];

    generate
        if (EDGE) begin : g_edge
            logic prev_r;

            // Previous synchronized value of bit 0 for edge detection
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_r <= 1'b0;
                end else begin
                    prev_r <= q[0];
                end
            end

            assign rise = q[0] & ~prev_r;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pt8211_rx.sv
// PT8211 receive deserializer: oversamples BCK/WS/DIN on clkin and delivers
// LSB-justified stereo frames through a single-entry valid/ready holding register.
module pt8211_rx #(
    parameter int WORD_W      = pt8211_pkg::WORD_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 256
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              bck_i,
    input  logic              ws_i,
    input  logic              din_i,
    output logic [WORD_W-1:0] left_o,
    output logic [WORD_W-1:0] right_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o,
    output logic              short_o,
    output logic              link_o
);
    import pt8211_pkg::*;

    localparam logic [5:0]      CNT_FULL = 6'(WORD_W);
    localparam logic [5:0]      CNT_MAX  = 6'd63;
    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

    logic       unused_bck_q_s;
    logic       bck_rise_s;
    logic [1:0] wsd_q_s;
    logic       unused_wsd_rise_s;

    pt8211_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .EDGE(1'b1)) u_sync_bck (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (bck_i),
        .q     (unused_bck_q_s),
        .rise  (bck_rise_s)
    );

    pt8211_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(2), .EDGE(1'b0)) u_sync_wsd (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     ({ws_i, din_i}),
        .q     (wsd_q_s),
        .rise  (unused_wsd_rise_s)
    );

    logic              smp_rise_r, smp_ws_r, smp_din_r;
    rx_state_t         state_r, state_nxt;
    logic [WORD_W-1:0] shreg_r, shreg_nxt;
    logic [5:0]        cnt_r, cnt_nxt;
    logic              ws_prev_r, ws_prev_nxt;
    logic [WORD_W-1:0] left_stage_r, left_stage_nxt;
    logic [WORD_W-1:0] frame_left_r, frame_left_nxt;
    logic [WORD_W-1:0] frame_right_r, frame_right_nxt;
    logic              frame_new_r, frame_new_nxt;
    logic              short_r, short_nxt;
    logic              link_r;
    logic [WD_W-1:0]   wdog_r;
    logic [WORD_W-1:0] left_r, right_r;
    logic              valid_r, overrun_r;

    // Sample synchronized bck edge, ws and din together so they stay aligned
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            smp_rise_r <= 1'b0;
            smp_ws_r   <= 1'b0;
            smp_din_r  <= 1'b0;
        end else begin
            smp_rise_r <= bck_rise_s;
            smp_ws_r   <= wsd_q_s[1];
            smp_din_r  <= wsd_q_s[0];
        end
    end

    // Bit shifting, word capture, frame pairing and link state transitions
    always_comb begin
        state_nxt       = state_r;
        shreg_nxt       = shreg_r;
        cnt_nxt         = cnt_r;
        ws_prev_nxt     = ws_prev_r;
        left_stage_nxt  = left_stage_r;
        frame_left_nxt  = frame_left_r;
        frame_right_nxt = frame_right_r;
        frame_new_nxt   = 1'b0;
        short_nxt       = 1'b0;
        if (smp_rise_r) begin
            ws_prev_nxt = smp_ws_r;
            shreg_nxt   = {shreg_r[WORD_W-2:0], smp_din_r};
            if (smp_ws_r == ws_prev_r) begin
                cnt_nxt = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + 6'd1;
            end else begin
                // The register now holds the last WORD_W bits of the ending half-frame
                cnt_nxt = 6'd1;
                if (cnt_r < CNT_FULL) begin
                    short_nxt = 1'b1;
                    state_nxt = ST_DOWN;
                end else if (ws_prev_r == WS_LEFT) begin
                    left_stage_nxt = shreg_r;
                    state_nxt      = ST_HAVE_L;
                end else begin
                    if (state_r == ST_HAVE_L) begin
                        frame_new_nxt   = 1'b1;
                        frame_left_nxt  = left_stage_r;
                        frame_right_nxt = shreg_r;
                    end else begin
                        frame_new_nxt = 1'b0;
                    end
                    state_nxt = ST_WAIT_L;
                end
            end
        end else if (wdog_r == WD_LIMIT) begin
            state_nxt   = ST_DOWN;
            cnt_nxt     = 6'd0;
            ws_prev_nxt = smp_ws_r;
        end else begin
            state_nxt = state_r;
        end
    end

    // Receive state registers and BCK watchdog
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_DOWN;
            shreg_r       <= '0;
            cnt_r         <= 6'd0;
            ws_prev_r     <= 1'b0;
            left_stage_r  <= '0;
            frame_left_r  <= '0;
            frame_right_r <= '0;
            frame_new_r   <= 1'b0;
            short_r       <= 1'b0;
            link_r        <= 1'b0;
            wdog_r        <= '0;
        end else begin
            state_r       <= state_nxt;
            shreg_r       <= shreg_nxt;
            cnt_r         <= cnt_nxt;
            ws_prev_r     <= ws_prev_nxt;
            left_stage_r  <= left_stage_nxt;
            frame_left_r  <= frame_left_nxt;
            frame_right_r <= frame_right_nxt;
            frame_new_r   <= frame_new_nxt;
            short_r       <= short_nxt;
            link_r        <= (state_nxt != ST_DOWN);
            if (smp_rise_r) begin
                wdog_r <= '0;
            end else if (wdog_r != WD_LIMIT) begin
                wdog_r <= wdog_r + WD_ONE;
            end else begin
                wdog_r <= wdog_r;
            end
        end
    end

    // Single-entry output holding register; a frame arriving while full is dropped
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            left_r    <= '0;
            right_r   <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (frame_new_r) begin
                if (!valid_r || ready_i) begin
                    left_r  <= frame_left_r;
                    right_r <= frame_right_r;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && ready_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign left_o    = left_r;
    assign right_o   = right_r;
    assign valid_o   = valid_r;
    assign overrun_o = overrun_r;
    assign short_o   = short_r;
    assign link_o    = link_r;

endmodule

// File: tb/tb_pt8211_rx.sv
// Self-checking bench for pt8211_rx: drives PT8211 half-frames and compares
// delivered frames and pulses against a half-frame level reference model.
module tb_pt8211_rx;

    localparam int W        = 16;
    localparam int BCK_HALF = 9;

    logic         clkin, rst_n, bck_i, ws_i, din_i, ready_i;
    logic [W-1:0] left_o, right_o;
    logic         valid_o, overrun_o, short_o, link_o;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [31:0]  got_q[$];
    int           short_cnt = 0;
    int           ovr_cnt   = 0;
    int           stab_err  = 0;
    logic         hold_prev = 1'b0;
    logic [W-1:0] hold_l = '0;
    logic [W-1:0] hold_r = '0;

    pt8211_rx #(.WORD_W(W), .SYNC_STAGES(2), .TIMEOUT(256)) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .bck_i     (bck_i),
        .ws_i      (ws_i),
        .din_i     (din_i),
        .left_o    (left_o),
        .right_o   (right_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .overrun_o (overrun_o),
        .short_o   (short_o),
        .link_o    (link_o)
    );

    initial begin
        clkin = 1'b0;
        forever #19 clkin = ~clkin;
    end

    // Output monitor: transfers, pulses and hold stability
    always @(negedge clkin) begin
        if (rst_n) begin
            if (valid_o && ready_i) got_q.push_back({left_o, right_o});
            if (short_o) short_cnt++;
            if (overrun_o) ovr_cnt++;
            if (hold_prev && (left_o !== hold_l || right_o !== hold_r)) stab_err++;
            hold_prev = valid_o && !ready_i;
            hold_l    = left_o;
            hold_r    = right_o;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic send_half(input logic ws, input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            bck_i = 1'b0;
            ws_i  = ws;
            din_i = val[i];
            repeat (BCK_HALF) @(negedge clkin);
            bck_i = 1'b1;
            repeat (BCK_HALF) @(negedge clkin);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
        send_half(1'b0, l, 16);
        send_half(1'b1, r, 16);
    endtask

    task automatic flush();
        send_half(1'b0, 32'h0, 2);
        repeat (20) @(negedge clkin);
    endtask

    task automatic wait_idle();
        bck_i = 1'b0;
        repeat (300) @(negedge clkin);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clkin);
        #1 ready_i = r;
    endtask

    task automatic test_reset();
        n_checks++; if (left_o !== 16'h0) begin n_fail++; $display("FAIL reset_left: got %h want %h", left_o, 16'h0); end
        n_checks++; if (right_o !== 16'h0) begin n_fail++; $display("FAIL reset_right: got %h want %h", right_o, 16'h0); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        n_checks++; if (short_o !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %b want 0", short_o); end
        n_checks++; if (link_o !== 1'b0) begin n_fail++; $display("FAIL reset_link: got %b want 0", link_o); end
    endtask

    task automatic test_nominal();
        int base_got = got_q.size();
        int base_sh  = short_cnt;
        int base_ov  = ovr_cnt;
        n_checks++; if (link_o !== 1'b0) begin n_fail++; $display("FAIL nominal_link_before: got %b want 0", link_o); end
        send_frame(32'h1234, 32'hFEDC);
        n_checks++; if (link_o !== 1'b1) begin n_fail++; $display("FAIL nominal_link_up: got %b want 1", link_o); end
        send_frame(32'h1234, 32'hFEDC);
        send_frame(32'h1234, 32'hFEDC);
        flush();
        n_checks++; if (got_q.size() - base_got !== 3) begin n_fail++; $display("FAIL nominal_count: got %0d want 3", got_q.size() - base_got); end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] g;
            g = (base_got + i < got_q.size()) ? got_q[base_got + i] : 32'hxxxxxxxx;
            n_checks++; if (g !== 32'h1234FEDC) begin n_fail++; $display("FAIL nominal_frame%0d: got %h want %h", i, g, 32'h1234FEDC); end
        end
        n_checks++; if (short_cnt - base_sh !== 0) begin n_fail++; $display("FAIL nominal_short: got %0d want 0", short_cnt - base_sh); end
        n_checks++; if (ovr_cnt - base_ov !== 0) begin n_fail++; $display("FAIL nominal_overrun: got %0d want 0", ovr_cnt - base_ov); end
        wait_idle();
    endtask

    task automatic test_latency();
        int base_got = got_q.size();
        send_half(1'b0, 32'h1111, 16);
        send_half(1'b1, 32'h2222, 16);
        bck_i = 1'b0; ws_i = 1'b0; din_i = 1'b0;
        repeat (BCK_HALF) @(negedge clkin);
        bck_i = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(posedge clkin);
            #1;
            n_checks++;
            if (valid_o !== (k == 4)) begin n_fail++; $display("FAIL latency_edge%0d: got %b want %b", k, valid_o, (k == 4)); end
        end
        repeat (BCK_HALF) @(negedge clkin);
        n_checks++; if (got_q.size() - base_got !== 1) begin n_fail++; $display("FAIL latency_count: got %0d want 1", got_q.size() - base_got); end
        wait_idle();
    endtask

    task automatic test_lsb_justify();
        int base_got = got_q.size();
        int base_sh  = short_cnt;
        logic [31:0] g;
        send_half(1'b0, 32'h00A58001, 24);
        send_half(1'b1, 32'h005A7FFE, 24);
        flush();
        g = (base_got < got_q.size()) ? got_q[base_got] : 32'hxxxxxxxx;
        n_checks++; if (got_q.size() - base_got !== 1) begin n_fail++; $display("FAIL lsb_count: got %0d want 1", got_q.size() - base_got); end
        n_checks++; if (g[31:16] !== 16'h8001) begin n_fail++; $display("FAIL lsb_left: got %h want %h", g[31:16], 16'h8001); end
        n_checks++; if (g[15:0] !== 16'h7FFE) begin n_fail++; $display("FAIL lsb_right: got %h want %h", g[15:0], 16'h7FFE); end
        n_checks++; if (short_cnt - base_sh !== 0) begin n_fail++; $display("FAIL lsb_short: got %0d want 0", short_cnt - base_sh); end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int base_got = got_q.size();
        int base_ov  = ovr_cnt;
        int base_st  = stab_err;
        logic [31:0] g;
        set_ready(1'b0);
        send_frame(32'h0001, 32'h0002);
        send_frame(32'h0003, 32'h0004);
        send_frame(32'h0005, 32'h0006);
        flush();
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", valid_o); end
        n_checks++; if (left_o !== 16'h0001) begin n_fail++; $display("FAIL bp_left: got %h want %h", left_o, 16'h0001); end
        n_checks++; if (right_o !== 16'h0002) begin n_fail++; $display("FAIL bp_right: got %h want %h", right_o, 16'h0002); end
        n_checks++; if (ovr_cnt - base_ov !== 2) begin n_fail++; $display("FAIL bp_overruns: got %0d want 2", ovr_cnt - base_ov); end
        n_checks++; if (stab_err - base_st !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", stab_err - base_st); end
        n_checks++; if (got_q.size() - base_got !== 0) begin n_fail++; $display("FAIL bp_no_xfer: got %0d want 0", got_q.size() - base_got); end
        set_ready(1'b1);
        @(posedge clkin);
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", valid_o); end
        g = (base_got < got_q.size()) ? got_q[base_got] : 32'hxxxxxxxx;
        n_checks++; if (g !== 32'h00010002) begin n_fail++; $display("FAIL bp_xfer: got %h want %h", g, 32'h00010002); end
        wait_idle();
    endtask

    task automatic test_short();
        int base_got = got_q.size();
        int base_sh  = short_cnt;
        logic [31:0] g;
        send_half(1'b0, 32'h0123, 12);
        send_half(1'b1, 32'h0456, 16);
        n_checks++; if (short_cnt - base_sh !== 1) begin n_fail++; $display("FAIL short_pulse: got %0d want 1", short_cnt - base_sh); end
        n_checks++; if (link_o !== 1'b0) begin n_fail++; $display("FAIL short_link: got %b want 0", link_o); end
        send_frame(32'h0AAA, 32'h0555);
        flush();
        g = (base_got < got_q.size()) ? got_q[base_got] : 32'hxxxxxxxx;
        n_checks++; if (got_q.size() - base_got !== 1) begin n_fail++; $display("FAIL short_count: got %0d want 1", got_q.size() - base_got); end
        n_checks++; if (g !== 32'h0AAA0555) begin n_fail++; $display("FAIL short_next_frame: got %h want %h", g, 32'h0AAA0555); end
        n_checks++; if (link_o !== 1'b1) begin n_fail++; $display("FAIL short_relink: got %b want 1", link_o); end
        wait_idle();
    endtask

    task automatic test_random();
        logic        ws_q[$];
        logic [31:0] val_q[$];
        int          nb_q[$];
        logic [31:0] exp_q[$];
        int          exp_short = 0;
        logic        have = 1'b0;
        logic [15:0] pend = '0;
        int          base_got = got_q.size();
        int          base_sh  = short_cnt;
        int          base_ov  = ovr_cnt;
        for (int f = 0; f < 10; f++) begin
            for (int c = 0; c < 2; c++) begin
                ws_q.push_back(c == 1);
                val_q.push_back($urandom);
                if ($urandom_range(0, 9) == 0) nb_q.push_back(int'($urandom_range(4, 15)));
                else nb_q.push_back(16 + int'($urandom_range(0, 8)));
            end
        end
        // Reference: words are the last 16 bits of each half; short halves break pairing
        for (int h = 0; h < ws_q.size(); h++) begin
            logic [31:0] v;
            v = val_q[h];
            if (nb_q[h] < 16) begin
                exp_short++;
                have = 1'b0;
            end else if (!ws_q[h]) begin
                pend = v[15:0];
                have = 1'b1;
            end else if (have) begin
                exp_q.push_back({pend, v[15:0]});
                have = 1'b0;
            end
        end
        for (int h = 0; h < ws_q.size(); h++) send_half(ws_q[h], val_q[h], nb_q[h]);
        flush();
        n_checks++; if (short_cnt - base_sh !== exp_short) begin n_fail++; $display("FAIL rand_short: got %0d want %0d", short_cnt - base_sh, exp_short); end
        n_checks++; if (ovr_cnt - base_ov !== 0) begin n_fail++; $display("FAIL rand_overrun: got %0d want 0", ovr_cnt - base_ov); end
        n_checks++; if (got_q.size() - base_got !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - base_got, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [31:0] g;
            g = (base_got + i < got_q.size()) ? got_q[base_got + i] : 32'hxxxxxxxx;
            n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL rand_frame%0d: got %h want %h", i, g, exp_q[i]); end
        end
        wait_idle();
    endtask

    task automatic test_timeout_reset();
        int base_got;
        logic [31:0] g;
        send_frame(32'h4321, 32'h8765);
        send_half(1'b0, 32'h0, 2);
        repeat (240) @(posedge clkin);
        #1;
        n_checks++; if (link_o !== 1'b1) begin n_fail++; $display("FAIL timeout_link_early: got %b want 1", link_o); end
        repeat (20) @(posedge clkin);
        #1;
        n_checks++; if (link_o !== 1'b0) begin n_fail++; $display("FAIL timeout_link_down: got %b want 0", link_o); end
        wait_idle();
        // Hold a frame, then reset in the middle of the next word
        set_ready(1'b0);
        send_frame(32'h1357, 32'h2468);
        send_half(1'b0, 32'h0, 6);
        repeat (20) @(negedge clkin);
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", valid_o); end
        send_half(1'b0, 32'hFF, 5);
        #7 rst_n = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        n_checks++; if (left_o !== 16'h0) begin n_fail++; $display("FAIL rst_left: got %h want 0", left_o); end
        n_checks++; if (right_o !== 16'h0) begin n_fail++; $display("FAIL rst_right: got %h want 0", right_o); end
        n_checks++; if (link_o !== 1'b0) begin n_fail++; $display("FAIL rst_link: got %b want 0", link_o); end
        bck_i = 1'b0; ws_i = 1'b0; din_i = 1'b0;
        repeat (3) @(negedge clkin);
        rst_n = 1'b1;
        set_ready(1'b1);
        base_got = got_q.size();
        send_frame(32'h0F0F, 32'hF0F0);
        flush();
        g = (base_got < got_q.size()) ? got_q[base_got] : 32'hxxxxxxxx;
        n_checks++; if (got_q.size() - base_got !== 1) begin n_fail++; $display("FAIL restart_count: got %0d want 1", got_q.size() - base_got); end
        n_checks++; if (g !== 32'h0F0FF0F0) begin n_fail++; $display("FAIL restart_frame: got %h want %h", g, 32'h0F0FF0F0); end
        n_checks++; if (link_o !== 1'b1) begin n_fail++; $display("FAIL restart_link: got %b want 1", link_o); end
    endtask

    initial begin
        #4000000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        rst_n   = 1'b0;
        bck_i   = 1'b0;
        ws_i    = 1'b0;
        din_i   = 1'b0;
        ready_i = 1'b1;
        repeat (5) @(negedge clkin);
        test_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clkin);
        test_nominal();
        test_latency();
        test_lsb_justify();
        test_backpressure();
        test_short();
        test_random();
        test_timeout_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pt8211_rx.md
Name: pt8211_rx

Overview:
- Receive-side deserializer for the PT8211 serial audio format (BCK/WS/DIN, 16-bit two's complement, MSB first, LSB-justified).
- Runs on the 27 MHz board clock and oversamples an externally supplied BCK (≤ clkin/4).
- Delivers stereo frames through a valid/ready handshake.
- Used for loopback verification of the DAC transmit path and for capturing external PT8211-format streams.

Parameters:
- WORD_W, 16, bits per channel word.
- SYNC_STAGES, 2, synchronizer flops on bck_i/ws_i/din_i (min 2).
- TIMEOUT, 256, clkin cycles without a BCK rising edge before the link is declared down.

Ports:
- clkin  in  1  system clock, 27 MHz.
- rst_n  in  1  asynchronous active-low reset.
- bck_i  in  1  serial bit clock, asynchronous to clkin.
- ws_i  in  1  word select: 0 = left, 1 = right.
- din_i  in  1  serial data.
- left_o  out  WORD_W  left sample of the held frame.
- right_o  out  WORD_W  right sample of the held frame.
- valid_o  out  1  frame held and valid.
- ready_i  in  1  consumer accepts the frame.
- overrun_o  out  1  one-cycle pulse: a frame was dropped.
- short_o  out  1  one-cycle pulse: a half-frame had fewer than WORD_W bits.
- link_o  out  1  stream is present and well-formed.

Behaviour:
- Reset values: left_o=0, right_o=0, valid_o=0, overrun_o=0, short_o=0, link_o=0. Internally: have_left=0, bit count=0, watchdog=0.
- Reset is async-asserted; all state clears immediately, including mid-word or mid-frame. No partial frame survives reset.
- bck_i, ws_i and din_i pass through identical SYNC_STAGES flop chains, so they stay aligned. A BCK rising edge (bck_rise) is sync_out=1 with the previous value 0.
- On bck_rise, the synchronized ws and din are sampled. ws_prev holds the ws value from the previous bck_rise.
- No WS change (ws == ws_prev): shift din into a WORD_W shift register (LSB enters, MSB-first order). Bit count increments and saturates at 63.
- WS change (ws != ws_prev): the shift register holds the last WORD_W bits of the ending half-frame (LSB-justified).
  - If bit count >= WORD_W: capture. ws_prev=0 loads the left staging register and sets have_left. ws_prev=1 completes a right word.
  - If bit count < WORD_W: pulse short_o, discard the word, clear have_left.
  - Then shift the current din in and set bit count to 1.
- Extra bits beyond WORD_W in a half-frame are ignored; only the last WORD_W are kept.
- Frame completion:
  - A valid right capture with have_left=1 forms a frame and clears have_left.
  - A right capture with have_left=0 (e.g. first word after reset or link-up) is discarded silently.
- Output handshake (single-entry holding register):
  - A transfer happens on any cycle with valid_o && ready_i.
  - New frame and (!valid_o || ready_i): load left_o/right_o, valid_o=1.
  - New frame, valid_o=1 and ready_i=0: keep the old frame, drop the new one, pulse overrun_o.
  - Transfer with no new frame: valid_o=0.
  - left_o/right_o are stable while valid_o=1 and ready_i=0.
- Latency: valid_o rises SYNC_STAGES+2 clkin cycles after the clkin edge that first registers bck_i high on the BCK edge where ws_i changes 1->0.
- Watchdog:
  - The counter clears on bck_rise and otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: link_o=0, have_left=0, bit count=0, ws_prev loaded from synchronized ws.
  - link_o=1 on the first capture with full bit count.
  - A short_o event also drops link_o.
- State machine on (link_o, have_left):
  - DOWN: link_o=0.
  - WAIT_L: link_o=1, have_left=0.
  - HAVE_L: link_o=1, have_left=1.
  - Transitions: DOWN->WAIT_L on a full-length right capture; DOWN->HAVE_L on a full-length left capture. HAVE_L->WAIT_L on frame emit. Any->DOWN on timeout or short.
- WS toggling without any bck_rise has no effect.

Decomposition:
- Package pt8211_pkg: WORD_W default (16), channel encoding (WS_LEFT=0, WS_RIGHT=1), and a sample type of WORD_W signed bits. The transmitter shares this package.
- Sub-module pt8211_sync_edge: an N-stage synchronizer with a rising-edge output. Instantiated for bck; a no-edge variant is used for ws/din.

Test Plan:
- Nominal: BCK 1.5 MHz, 32 BCK per frame, left=16'h1234, right=16'hFEDC, ready_i=1 -> one valid_o pulse per frame with left_o=1234, right_o=FEDC; link_o=1 from the first left capture.
- LSB-justify: 24 BCK per half-frame with 8 leading junk bits 8'hA5, left=16'h8001 -> left_o=8001; no short_o.
- Backpressure: hold ready_i=0 over 3 frames (L/R = 0001/0002, 0003/0004, 0005/0006) -> outputs stay 0001/0002; two overrun_o pulses. Raise ready_i -> transfer, valid_o=0 the next cycle.
- Short word: a 12-bit left half-frame -> short_o pulse, link_o=0, the following right word discarded; the next full frame 0AAA/0555 is delivered.
- Timeout and reset: stop BCK for 300 clkin cycles -> link_o=0 at cycle 256. Assert rst_n mid-word -> all outputs 0 immediately. Restart -> the first full frame is delivered.
